wb_dpbram: RTL and testbench

Fixed-latency delay line built on a simple dual-port block RAM. Every clock cycle one byte is written through port A into a circular buffer, and the byte written DEPTH cycles earlier is read through port B onto the output register. The block sits in a streaming datapath wherever a deterministic DEPTH-cycle delay of a byte stream is needed. It is the team's reference wrapper for inferring true BRAM with read-first collision behaviour.

---
 rtl/wb_dpbram.sv | 65 ++++++
 tb/tb_wb_dpbram.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wb_dpbram.sv
// Fixed DEPTH-cycle byte delay line on a simple dual-port RAM with read-first
// collision behaviour; output is held at zero until the buffer has been filled once.
module wb_dpbram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW:0] FILL_FULL = DEPTH[AW:0];

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_fill;
    logic [DW-1:0] r_out;
    logic          w_primed;

    // Primed once DEPTH writes have landed since reset; gates stale RAM contents.
    always_comb begin
        w_primed = 1'b0;
        if (r_fill == FILL_FULL) begin
            w_primed = 1'b1;
        end else begin
            w_primed = 1'b0;
        end
    end

    // Port A: unconditional write each edge; no reset so the array maps to BRAM.
    always_ff @(posedge i_clk) begin
        r_mem[r_wr_ptr] <= i_data;
    end

    // Write pointer wraps naturally; fill counter saturates at DEPTH.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_fill   <= {(AW + 1){1'b0}};
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + (AW + 1)'(1);
            end else begin
                r_fill <= r_fill;
            end
        end
    end

    // Port B: same address as the write, sampled before the write lands (read-first).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_out <= {DW{1'b0}};
        end else if (!w_primed) begin
            r_out <= {DW{1'b0}};
        end else begin
            r_out <= r_mem[r_wr_ptr];
        end
    end

    assign o_data = r_out;

endmodule

// File: tb/tb_wb_dpbram.sv
// Scoreboard bench for wb_dpbram: one DEPTH-4 instance and one default DEPTH-16 instance.
module tb_wb_dpbram;

    logic       clk;
    logic       rst2_n;
    logic       rst4_n;
    logic [7:0] d2;
    logic [7:0] d4;
    logic [7:0] o2;
    logic [7:0] o4;

    int n_vec;
    int n_bad;

    logic [7:0] q2[$];
    logic [7:0] q4[$];

    wb_dpbram #(.AW(2), .DW(8)) u_dut2 (
        .i_clk     (clk),
        .i_reset_n (rst2_n),
        .i_data    (d2),
        .o_data    (o2)
    );

    wb_dpbram u_dut4 (
        .i_clk     (clk),
        .i_reset_n (rst4_n),
        .i_data    (d4),
        .o_data    (o4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT output update just after the edge is compared against the queue head.
    always @(posedge clk) begin
        #1;
        if (q2.size() > 0) check("dut2_out", o2, q2.pop_front());
        if (q4.size() > 0) check("dut4_out", o4, q4.pop_front());
    end

    // Called at a falling edge: drive the sample, queue the response expected after the next rising edge.
    task automatic step2(input logic [7:0] d, input logic [7:0] exp);
        d2 = d;
        q2.push_back(exp);
        @(negedge clk);
    endtask

    task automatic step4(input logic [7:0] d, input logic [7:0] exp);
        d4 = d;
        q4.push_back(exp);
        @(negedge clk);
    endtask

    logic [7:0] fill_in  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] fill_exp [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    logic [7:0] coll_in  [12] = '{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'hAA, 8'hAB,
                                  8'hAC, 8'hAD, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] coll_exp [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5B,
                                  8'h5C, 8'h5D, 8'hAA, 8'hAB, 8'hAC, 8'hAD};
    logic [7:0] rnd_in   [20] = '{8'hC3, 8'h7E, 8'h19, 8'hF0, 8'h4D, 8'hA2, 8'h38, 8'h9B,
                                  8'h66, 8'hE1, 8'h0F, 8'hD4, 8'h52, 8'hB7, 8'h2C, 8'h85,
                                  8'h3A, 8'hC9, 8'h71, 8'hEE};

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        rst2_n = 1'b0;
        rst4_n = 1'b0;
        d2     = 8'h00;
        d4     = 8'h00;
        #2;
        check("reset_initial", o2, 8'h00);
        @(negedge clk);

        // Held in reset with toggling data
        for (int i = 0; i < 4; i++) step2(8'hA5 ^ 8'(i * 37), 8'h00);

        // Fill
        rst2_n = 1'b1;
        for (int i = 0; i < 6; i++) step2(fill_in[i], fill_exp[i]);

        // Wrap: fresh reset, stream 0x00..0x0F
        rst2_n = 1'b0;
        step2(8'hFF, 8'h00);
        rst2_n = 1'b1;
        for (int k = 0; k < 16; k++) step2(8'(k), (k < 4) ? 8'h00 : 8'(k - 4));

        // Read-first collision
        rst2_n = 1'b0;
        step2(8'h00, 8'h00);
        rst2_n = 1'b1;
        for (int i = 0; i < 12; i++) step2(coll_in[i], coll_exp[i]);

        // Reset mid-stream with asynchronous assertion
        rst2_n = 1'b0;
        step2(8'h00, 8'h00);
        rst2_n = 1'b1;
        for (int k = 0; k < 7; k++) step2(8'h80 + 8'(k), (k < 4) ? 8'h00 : 8'h80 + 8'(k - 4));
        check("pre_async_reset", o2, 8'h82);
        rst2_n = 1'b0;
        #1;
        check("async_reset_clear", o2, 8'h00);
        step2(8'h87, 8'h00);
        step2(8'h88, 8'h00);
        rst2_n = 1'b1;
        for (int k = 0; k < 8; k++) step2(8'(k + 1), (k < 4) ? 8'h00 : 8'(k - 3));

        // Default depth 16
        rst4_n = 1'b1;
        for (int k = 0; k < 20; k++) step4(rnd_in[k], (k < 16) ? 8'h00 : rnd_in[k - 16]);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
